// File: rtl/maxpool2x2.sv
// maxpool2x2: stride-2 2x2 signed max-pool over a channel-major map in temp BRAM.
// Define MAXPOOL_RELU_EN to clamp each pooled result at zero (fused ReLU).
module maxpool2x2 #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int IN_W     = 14,
    parameter int IN_H     = 14,
    parameter int CH       = 6,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 1176
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] BRAM_TEMP_ADDR,
    output logic              BRAM_TEMP_EN,
    output logic              BRAM_TEMP_WE,
    output logic [DATA_W-1:0] BRAM_TEMP_DIN,
    input  logic [DATA_W-1:0] BRAM_TEMP_DOUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_WR,
        S_DONE
    } state_t;

    localparam int OW = IN_W / 2;
    localparam int OH = IN_H / 2;

    localparam logic [ADDR_W-1:0] OW_LAST  = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] OH_LAST  = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] CH_LAST  = ADDR_W'(CH - 1);
    localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IN_W);
    localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(IN_H * IN_W);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] ox_q, ox_d;
    logic [ADDR_W-1:0] oy_q, oy_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] ch_q, ch_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] win_q, win_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [DATA_W-1:0] pooled;
    logic [DATA_W-1:0] wr_data;
    logic              last;

    function automatic logic [DATA_W-1:0] smax(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    always_comb begin
        pooled = smax(acc_q, BRAM_TEMP_DOUT);
`ifdef MAXPOOL_RELU_EN
        wr_data = pooled[DATA_W-1] ? '0 : pooled;
`else
        wr_data = pooled;
`endif
    end

    assign last = (ox_q == OW_LAST) && (oy_q == OH_LAST) && (c_q == CH_LAST);
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d        = state_q;
        ox_d           = ox_q;
        oy_d           = oy_q;
        c_d            = c_q;
        ch_d           = ch_q;
        row_d          = row_q;
        win_d          = win_q;
        dst_d          = dst_q;
        acc_d          = acc_q;
        BRAM_TEMP_ADDR = '0;
        BRAM_TEMP_EN   = 1'b0;
        BRAM_TEMP_WE   = 1'b0;
        BRAM_TEMP_DIN  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD0;
                    ox_d    = '0;
                    oy_d    = '0;
                    c_d     = '0;
                    ch_d    = SRC_A;
                    row_d   = SRC_A;
                    win_d   = SRC_A;
                    dst_d   = DST_A;
                end
            end
            S_RD0: begin
                BRAM_TEMP_EN   = 1'b1;
                BRAM_TEMP_ADDR = win_q;
                state_d        = S_RD1;
            end
            S_RD1: begin
                BRAM_TEMP_EN   = 1'b1;
                BRAM_TEMP_ADDR = win_q + ONE;
                acc_d          = BRAM_TEMP_DOUT;
                state_d        = S_RD2;
            end
            S_RD2: begin
                BRAM_TEMP_EN   = 1'b1;
                BRAM_TEMP_ADDR = win_q + ROW_W;
                acc_d          = pooled;
                state_d        = S_RD3;
            end
            S_RD3: begin
                BRAM_TEMP_EN   = 1'b1;
                BRAM_TEMP_ADDR = win_q + ROW_W + ONE;
                acc_d          = pooled;
                state_d        = S_WR;
            end
            S_WR: begin
                BRAM_TEMP_EN   = 1'b1;
                BRAM_TEMP_WE   = 1'b1;
                BRAM_TEMP_ADDR = dst_q;
                BRAM_TEMP_DIN  = wr_data;
                dst_d          = dst_q + ONE;
                state_d        = last ? S_DONE : S_RD0;
                // Row/channel bases are tracked so an odd trailing column/row is skipped
                if (ox_q == OW_LAST) begin
                    ox_d = '0;
                    if (oy_q == OH_LAST) begin
                        oy_d  = '0;
                        c_d   = c_q + ONE;
                        ch_d  = ch_q + CH_STEP;
                        row_d = ch_q + CH_STEP;
                        win_d = ch_q + CH_STEP;
                    end else begin
                        oy_d  = oy_q + ONE;
                        row_d = row_q + ROW_STEP;
                        win_d = row_q + ROW_STEP;
                    end
                end else begin
                    ox_d  = ox_q + ONE;
                    win_d = win_q + TWO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            c_q     <= '0;
            ch_q    <= '0;
            row_q   <= '0;
            win_q   <= '0;
            dst_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            c_q     <= c_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            win_q   <= win_d;
            dst_q   <= dst_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_maxpool2x2.sv
// tb_maxpool2x2: random/directed runs of maxpool2x2 against a window-max model.
// Build with MAXPOOL_RELU_EN defined to check the fused-ReLU variant.
module tb_maxpool2x2;

    localparam int IW  = 14;
    localparam int IH  = 14;
    localparam int CHN = 6;
    localparam int OW  = IW / 2;
    localparam int OH  = IH / 2;
    localparam int N   = CHN * OH * OW;
    localparam int SRC = 0;
    localparam int DST = 1176;
    localparam int MSZ = 4096;
`ifdef MAXPOOL_RELU_EN
    localparam logic [7:0] NEG_EXP = 8'h00;
`else
    localparam logic [7:0] NEG_EXP = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        rst, start, start_b, load, load_b;
    logic        done, busy, en, we;
    logic [15:0] addr;
    logic [7:0]  din, dout;
    logic        done_b, busy_b, en_b, we_b;
    logic [15:0] addr_b;
    logic [7:0]  din_b, dout_b;

    logic [7:0] mem[MSZ];
    logic [7:0] mem_b[MSZ];
    logic [7:0] img[MSZ];
    logic [7:0] exp_out[N];
    logic [7:0] exp_ramp[N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int last_done_k = 0;
    bit running = 1'b0;

    always #5 clk = ~clk;

    maxpool2x2 dut (
        .clk(clk), .rst(rst), .start(start),
        .done(done), .busy(busy),
        .BRAM_TEMP_ADDR(addr), .BRAM_TEMP_EN(en),
        .BRAM_TEMP_WE(we), .BRAM_TEMP_DIN(din),
        .BRAM_TEMP_DOUT(dout)
    );

    maxpool2x2 #(.SRC_BASE(0), .DST_BASE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .done(done_b), .busy(busy_b),
        .BRAM_TEMP_ADDR(addr_b), .BRAM_TEMP_EN(en_b),
        .BRAM_TEMP_WE(we_b), .BRAM_TEMP_DIN(din_b),
        .BRAM_TEMP_DOUT(dout_b)
    );

    // Read-first single-port BRAMs with one-cycle read latency
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < MSZ; i++) mem[i] = img[i];
        end else if (en) begin
            if (addr[15:12] == 4'd0) begin
                dout <= mem[addr[11:0]];
                if (we) mem[addr[11:0]] = din;
            end else begin
                dout <= 'x;
            end
        end
    end

    always @(posedge clk) begin
        if (load_b) begin
            for (int i = 0; i < MSZ; i++) mem_b[i] = img[i];
        end else if (en_b) begin
            if (addr_b[15:12] == 4'd0) begin
                dout_b <= mem_b[addr_b[11:0]];
                if (we_b) mem_b[addr_b[11:0]] = din_b;
            end else begin
                dout_b <= 'x;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, expv);
        end
    endtask

    function automatic int src_addr(input int n, input int p);
        int c, oy, ox;
        c  = n / (OH * OW);
        oy = (n / OW) % OH;
        ox = n % OW;
        return SRC + c * IH * IW + (2 * oy + p / 2) * IW + 2 * ox + p % 2;
    endfunction

    task automatic compute_expected();
        for (int n = 0; n < N; n++) begin
            int m;
            m = -128;
            for (int p = 0; p < 4; p++) begin
                int v;
                v = $signed(img[src_addr(n, p)]);
                if (v > m) m = v;
            end
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            exp_out[n] = 8'(m);
        end
    endtask

    task automatic monitor();
        int k, n, p;
        if (running) begin
            k = cyc - t0;
            if (k < 5 * N) begin
                n = k / 5;
                p = k % 5;
                check("busy", busy, 1);
                check("done", done, 0);
                check("en", en, 1);
                if (p == 4) begin
                    check("we", we, 1);
                    check("wr_addr", addr, DST + n);
                    check("din", din, exp_out[n]);
                end else begin
                    check("we", we, 0);
                    check("rd_addr", addr, src_addr(n, p));
                end
            end else begin
                check("done", done, 1);
                check("busy", busy, 1);
                check("en", en, 0);
                check("we", we, 0);
            end
        end else begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_en", en, 0);
            check("idle_we", we, 0);
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_k = cyc - t0;
        end
    endtask

    // Advance one clock; the run model follows the sampled rst/start
    task automatic tick();
        bit r, s;
        r = rst;
        s = start;
        @(posedge clk);
        cyc++;
        if (r) running = 1'b0;
        else if (!running) begin
            if (s) begin
                running = 1'b1;
                t0 = cyc;
            end
        end else if (cyc - t0 == 5 * N + 1) running = 1'b0;
        #1;
        monitor();
    endtask

    task automatic load_img();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int b;
        b = 0;
        while (done_cnt == d0 && b < 3000) begin
            tick();
            b++;
        end
        check("done_seen", done_cnt != d0, 1);
        tick();
        tick();
        check("done_pulses", done_cnt - d0, 1);
        check("done_lat", last_done_k, 5 * N);
    endtask

    task automatic run_full();
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0);
    endtask

    task automatic compare_dst();
        for (int n = 0; n < N; n++) check("dst", mem[DST + n], exp_out[n]);
    endtask

    initial begin
        int d0, b;
        rst = 1'b1;
        start = 1'b0;
        start_b = 1'b0;
        load = 1'b0;
        load_b = 1'b0;
        for (int i = 0; i < MSZ; i++) img[i] = 8'h00;
        @(posedge clk);
        #1;
        cyc = 1;
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_en", en, 0);
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_din", din, 0);
        rst = 1'b0;
        tick();

        // Ramp
        for (int i = 0; i < DST; i++) img[i] = 8'(i & 8'h7F);
        compute_expected();
        check("model_ramp0", exp_out[0], 8'h0F);
        check("model_ramp1", exp_out[1], 8'h11);
        exp_ramp = exp_out;
        load_img();
        run_full();
        check("ramp_dst0", mem[DST], 8'h0F);
        check("ramp_dst1", mem[DST + 1], 8'h11);
        compare_dst();

        // One -1 per window among -128s, rotating position
        for (int i = 0; i < DST; i++) img[i] = 8'h80;
        for (int n = 0; n < N; n++) img[src_addr(n, n % 4)] = 8'hFF;
        compute_expected();
        check("model_neg", exp_out[7], NEG_EXP);
        load_img();
        run_full();
        check("neg_first", mem[DST], NEG_EXP);
        check("neg_last", mem[DST + N - 1], NEG_EXP);
        compare_dst();

        // Random data with start re-pulsed mid-run and in the DONE cycle
        for (int i = 0; i < DST; i++) img[i] = 8'($urandom);
        compute_expected();
        load_img();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t0 + 49) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        b = 0;
        while (cyc < t0 + 5 * N && b < 3000) begin
            tick();
            b++;
        end
        check("done_cycle", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ignored", busy, 0);
        tick();
        check("restart_idle", busy, 0);
        check("single_done", done_cnt - d0, 1);
        compare_dst();

        // Reset mid-run, then a fresh run
        for (int i = 0; i < DST; i++) img[i] = 8'($urandom);
        compute_expected();
        load_img();
        start = 1'b1;
        tick();
        start = 1'b0;
        d0 = t0;
        while (cyc < d0 + 99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_we", we, 0);
        check("midrst_en", en, 0);
        check("midrst_busy", busy, 0);
        while (cyc < d0 + 109) tick();
        run_full();
        check("rerun_t", t0 - d0, 110);
        compare_dst();

        // In-place instance with ramp data
        for (int i = 0; i < MSZ; i++) img[i] = (i < DST) ? 8'(i & 8'h7F) : 8'h00;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        b = 0;
        while (done_b !== 1'b1 && b < 3000) begin
            tick();
            b++;
        end
        check("inplace_lat", b, 5 * N);
        for (int n = 0; n < N; n++) check("inplace", mem_b[n], exp_ramp[n]);
        tick();
        check("inplace_idle", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
